hazard_scheduler: RTL and testbench

Pipeline-wide stall and flush sequencer. It watches the decode and execute stages and the data-memory handshake, then drives the stall, bubble, flush and branch-reference controls consumed by every stage's pipeline unit. It resolves three event classes with fixed priority: data-memory wait, taken branch, and load-use hazard. It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_if.sv | 35 +++
 rtl/hazard_scheduler.sv | 97 +++++++++
 tb/tb_hazard_scheduler.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Decode/execute/memory hazard inputs and stall/flush controls exchanged
// between the pipeline (master) and the hazard scheduler (slave).
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       id_rn;
  logic [3:0]       id_rm;
  logic [3:0]       id_rs;
  logic             id_use_rn;
  logic             id_use_rm;
  logic             id_use_rs;
  logic [3:0]       ex_rd;
  logic             ex_is_load;
  logic             branch_taken;
  logic             mem_busy;
  logic             stat_clr;
  logic             sel_stall;
  logic             bubble;
  logic             stall_all;
  logic             flush;
  logic             branch_ref;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rn, id_rm, id_rs, id_use_rn, id_use_rm, id_use_rs,
    output ex_rd, ex_is_load, branch_taken, mem_busy, stat_clr,
    input  sel_stall, bubble, stall_all, flush, branch_ref, stall_count
  );

  modport slave (
    input  id_rn, id_rm, id_rs, id_use_rn, id_use_rm, id_use_rs,
    input  ex_rd, ex_is_load, branch_taken, mem_busy, stat_clr,
    output sel_stall, bubble, stall_all, flush, branch_ref, stall_count
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Pipeline stall/flush sequencer: memory wait > taken branch > load-use,
// plus a saturating stalled-cycle counter.
//
// state | meaning
// RUN   | normal issue; branches and load-use hazards are evaluated
// FLUSH | squashing wrong-path work for FLUSH_CYCLES non-busy cycles
module hazard_scheduler #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic     clk,
  input logic     rst_n,
  hazard_if.slave hz
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state_q;
  logic [1:0]       flush_cnt_q;
  logic             flush_q;
  logic             branch_ref_q;
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;

  logic luh;
  logic run_free;
  logic br_accept;
  logic sel_stall;
  logic stall_all;

  // A load to R15 is resolved through the branch path, never by stalling.
  assign luh = hz.ex_is_load && (hz.ex_rd != 4'hF) &&
               ((hz.id_use_rn && (hz.id_rn == hz.ex_rd)) ||
                (hz.id_use_rm && (hz.id_rm == hz.ex_rd)) ||
                (hz.id_use_rs && (hz.id_rs == hz.ex_rd)));

  assign run_free  = rst_n && !hz.mem_busy && (state_q == RUN);
  assign br_accept = run_free && hz.branch_taken;
  assign sel_stall = run_free && !hz.branch_taken && luh;
  assign stall_all = rst_n && hz.mem_busy;

  always_comb begin
    stall_count_d = stall_count_q;
    if (hz.stat_clr)
      stall_count_d = '0;
    else if ((sel_stall || stall_all) && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      flush_cnt_q   <= 2'd0;
      flush_q       <= 1'b0;
      branch_ref_q  <= 1'b0;
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      if (!hz.mem_busy) begin
        case (state_q)
          RUN: begin
            if (hz.branch_taken) begin
              state_q      <= FLUSH;
              flush_q      <= 1'b1;
              flush_cnt_q  <= 2'(FLUSH_CYCLES - 1);
              branch_ref_q <= !branch_ref_q;
            end
          end
          FLUSH: begin
            // Execute holds a wrong-path instruction here, so branch_taken is ignored.
            if (flush_cnt_q == 2'd0) begin
              state_q <= RUN;
              flush_q <= 1'b0;
            end else begin
              flush_cnt_q <= flush_cnt_q - 2'd1;
            end
          end
          default: begin
            state_q <= RUN;
            flush_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hz.sel_stall   = sel_stall;
  assign hz.bubble      = sel_stall;
  assign hz.stall_all   = stall_all;
  assign hz.flush       = flush_q;
  assign hz.branch_ref  = branch_ref_q;
  assign hz.stall_count = stall_count_q;

  logic unused_br;
  assign unused_br = br_accept;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: directed scenarios plus random
// traffic, checked against a cycle-level behavioural model.
module tb_hazard_scheduler;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 16;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_if #(.CNT_W(CNT_W)) hz ();

  hazard_scheduler #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  typedef struct {
    bit       rst_n;
    bit [3:0] rn, rm, rs, rd;
    bit       urn, urm, urs, ld, bt, mb, clr;
  } stim_t;

  typedef struct {
    bit sel, bub, sa, fl, bref;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: remaining flush cycles, branch epoch and stall tally.
  int m_left  = 0;
  bit m_epoch = 1'b0;
  int m_cnt   = 0;

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: '0};
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t luh_stim(bit use_rm, bit [3:0] rd);
    stim_t s;
    s = idle_stim();
    s.ld  = 1'b1;
    s.rd  = rd;
    s.urm = use_rm;
    s.rm  = 4'd3;
    return s;
  endfunction

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    bit   hit, free, br, sel;
    @(posedge clk);
    #1;
    hz.id_rn = s.rn; hz.id_rm = s.rm; hz.id_rs = s.rs;
    hz.id_use_rn = s.urn; hz.id_use_rm = s.urm; hz.id_use_rs = s.urs;
    hz.ex_rd = s.rd; hz.ex_is_load = s.ld;
    hz.branch_taken = s.bt; hz.mem_busy = s.mb; hz.stat_clr = s.clr;
    rst_n = s.rst_n;
    e = '{default: 0};
    if (!s.rst_n) begin
      m_left = 0; m_epoch = 1'b0; m_cnt = 0;
      q.push_back(e);
      return;
    end
    hit = s.ld && (s.rd != 4'd15) &&
          ((s.urn && s.rn == s.rd) || (s.urm && s.rm == s.rd) || (s.urs && s.rs == s.rd));
    free = !s.mb && (m_left == 0);
    br   = free && s.bt;
    sel  = free && !s.bt && hit;
    e.sel = sel; e.bub = sel; e.sa = s.mb;
    e.fl = (m_left > 0); e.bref = m_epoch; e.cnt = m_cnt;
    q.push_back(e);
    if (s.clr) m_cnt = 0;
    else if ((sel || s.mb) && m_cnt < CNT_MAX) m_cnt++;
    if (!s.mb) begin
      if (br) begin
        m_epoch = !m_epoch;
        m_left  = FLUSH_CYCLES;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sel_stall",   int'(hz.sel_stall),   int'(e.sel));
      chk("bubble",      int'(hz.bubble),      int'(e.bub));
      chk("stall_all",   int'(hz.stall_all),   int'(e.sa));
      chk("flush",       int'(hz.flush),       int'(e.fl));
      chk("branch_ref",  int'(hz.branch_ref),  int'(e.bref));
      chk("stall_count", int'(hz.stall_count), e.cnt);
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    hz.id_rn = '0; hz.id_rm = '0; hz.id_rs = '0;
    hz.id_use_rn = 1'b0; hz.id_use_rm = 1'b0; hz.id_use_rs = 1'b0;
    hz.ex_rd = '0; hz.ex_is_load = 1'b0;
    hz.branch_taken = 1'b0; hz.mem_busy = 1'b0; hz.stat_clr = 1'b0;

    // Reset with branch and memory wait asserted, then accept the branch.
    s = idle_stim(); s.rst_n = 1'b0; s.bt = 1'b1; s.mb = 1'b1;
    repeat (2) apply(s);
    s = idle_stim(); s.bt = 1'b1;
    apply(s);
    repeat (3) apply(idle_stim());

    // Load-use hit, R15 exemption, and unused source.
    apply(luh_stim(1'b1, 4'd3));
    apply(luh_stim(1'b1, 4'd15));
    apply(luh_stim(1'b0, 4'd3));
    apply(idle_stim());

    // Branch, then load-use stimulus during both flush cycles.
    s = idle_stim(); s.bt = 1'b1;
    apply(s);
    repeat (2) apply(luh_stim(1'b1, 4'd3));
    apply(idle_stim());

    // Memory wait of 4 cycles after the first flush cycle.
    s = idle_stim(); s.bt = 1'b1;
    apply(s);
    apply(idle_stim());
    s = idle_stim(); s.mb = 1'b1;
    repeat (4) apply(s);
    repeat (3) apply(idle_stim());

    // Branch held under memory wait, then accepted once.
    s = idle_stim(); s.bt = 1'b1; s.mb = 1'b1;
    repeat (3) apply(s);
    s.mb = 1'b0;
    apply(s);
    repeat (3) apply(idle_stim());

    // Branch beats a concurrent load-use hazard.
    s = luh_stim(1'b1, 4'd3); s.bt = 1'b1;
    apply(s);
    repeat (3) apply(idle_stim());

    // Reset in the middle of a flush.
    s = idle_stim(); s.bt = 1'b1;
    apply(s);
    s = idle_stim(); s.rst_n = 1'b0;
    apply(s);
    repeat (2) apply(idle_stim());

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      s = idle_stim();
      s.rn  = 4'($urandom_range(0, 3));
      s.rm  = 4'($urandom_range(0, 3));
      s.rs  = 4'($urandom_range(0, 3));
      s.rd  = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      s.urn = 1'($urandom); s.urm = 1'($urandom); s.urs = 1'($urandom);
      s.ld  = 1'($urandom);
      s.bt  = ($urandom_range(0, 5) == 0);
      s.mb  = ($urandom_range(0, 4) == 0);
      s.clr = ($urandom_range(0, 60) == 0);
      s.rst_n = ($urandom_range(0, 250) != 0);
      apply(s);
    end

    // Saturation: clear, run to 0xFFFE, then past the top, then clear with stall.
    s = idle_stim(); s.clr = 1'b1;
    apply(s);
    s = idle_stim(); s.mb = 1'b1;
    for (int i = 0; i < CNT_MAX - 1; i++) apply(s);
    repeat (3) apply(s);
    s.clr = 1'b1;
    apply(s);
    repeat (2) apply(idle_stim());

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
